secded_scrubber: RTL and testbench

SECDED_SCRUBBER -- requirements
Module: secded_scrubber

---
 rtl/secded_pkg.sv | 24 ++
 rtl/secded_dec.sv | 42 ++++
 rtl/secded_scrubber.sv | 134 +++++++++++++
 tb/tb_secded_scrubber.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared sizes, FSM state and error-class types for the SECDED memory scrubber.
package secded_pkg;

    localparam int DATA_W = 8;
    localparam int CW_W   = 13;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int SYN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_CLEAN,
        CLS_CORR,
        CLS_UNCORR
    } err_class_t;

endpackage

// File: rtl/secded_dec.sv
// Combinational SECDED decoder: Hamming(12,8) syndrome plus overall parity bit cw[12].
module secded_dec
    import secded_pkg::*;
(
    input  logic [CW_W-1:0] i_cw,
    output err_class_t      o_class,
    output logic [CW_W-1:0] o_cw_fixed
);

    logic [SYN_W-1:0] w_syn;
    logic             w_par;

    // Syndrome is the XOR of the 1-based positions of every set bit below the overall-parity bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_syn = '0;
        for (int i = 0; i < CW_W - 1; i++) begin
            if (i_cw[i]) begin
                w_syn = w_syn ^ SYN_W'(i + 1);
            end
        end
    end

    assign w_par = ^i_cw;

    always_comb begin
        o_class    = CLS_UNCORR;
        o_cw_fixed = i_cw;
        if (w_syn == '0) begin
            if (!w_par) begin
                o_class = CLS_CLEAN;
            end else begin
                o_class                = CLS_CORR;
                o_cw_fixed[CW_W-1]     = ~i_cw[CW_W-1];
            end
        end else if (w_par && (w_syn <= SYN_W'(CW_W - 1))) begin
            o_class    = CLS_CORR;
            o_cw_fixed = i_cw ^ (CW_W'(1) << (w_syn - SYN_W'(1)));
        end
    end

endmodule

// File: rtl/secded_scrubber.sv
// Sweeps a 16x13 SECDED memory, counting and (with SECDED_SCRUB_WRITEBACK_EN defined)
// writing back correctable words; uncorrectable words are counted and their address latched.
module secded_scrubber
    import secded_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [CW_W-1:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [CW_W-1:0]   mem_wr_data,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [ADDR_W-1:0] err_addr
);

`ifdef SECDED_SCRUB_WRITEBACK_EN
    localparam bit WRITEBACK = 1'b1;
`else
    localparam bit WRITEBACK = 1'b0;
`endif

    state_t             r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [CW_W-1:0]    r_word;
    logic               r_busy;
    logic               r_done;
    logic               r_wr_en;
    logic [CW_W-1:0]    r_wr_data;
    logic [CNT_W-1:0]   r_corr_cnt;
    logic [CNT_W-1:0]   r_uncorr_cnt;
    logic [ADDR_W-1:0]  r_err_addr;

    err_class_t         w_class;
    logic [CW_W-1:0]    w_fixed;
    logic               w_last;

    secded_dec u_dec (
        .i_cw       (r_word),
        .o_class    (w_class),
        .o_cw_fixed (w_fixed)
    );

    assign w_last = (r_ptr == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_word       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
            r_err_addr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_READ;
                        r_busy       <= 1'b1;
                        r_ptr        <= '0;
                        r_corr_cnt   <= '0;
                        r_uncorr_cnt <= '0;
                    end
                end
                ST_READ: begin
                    r_word  <= mem_rd_data;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_class == CLS_CORR && r_corr_cnt != '1) begin
                        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
                    end
                    if (w_class == CLS_UNCORR) begin
                        r_err_addr <= r_ptr;
                        if (r_uncorr_cnt != '1) begin
                            r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
                        end
                    end
                    if (WRITEBACK && w_class == CLS_CORR) begin
                        r_state   <= ST_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_fixed;
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_state <= ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_state <= ST_READ;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_addr    = r_ptr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_data = r_wr_data;
    assign corr_cnt    = r_corr_cnt;
    assign uncorr_cnt  = r_uncorr_cnt;
    assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_secded_scrubber.sv
// Table-driven sweep tests with a write scoreboard; honours SECDED_SCRUB_WRITEBACK_EN like the RTL.
`timescale 1ns/1ps
module tb_secded_scrubber;
    import secded_pkg::*;

    localparam int TB_CNT_W = 3;
`ifdef SECDED_SCRUB_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CW_W-1:0]     mem_rd_data;
    logic                mem_wr_en;
    logic [CW_W-1:0]     mem_wr_data;
    logic [TB_CNT_W-1:0] corr_cnt;
    logic [TB_CNT_W-1:0] uncorr_cnt;
    logic [ADDR_W-1:0]   err_addr;

    logic [CW_W-1:0]     mem [DEPTH];

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CW_W-1:0]   data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [CW_W-1:0]   fill;
        logic              fill_corr;
        logic [CW_W-1:0]   fill_fix;
        logic [ADDR_W-1:0] sp_addr;
        logic [CW_W-1:0]   sp_val;
        logic              sp_corr;
        logic [CW_W-1:0]   sp_fix;
        int                exp_corr;
        int                exp_uncorr;
        logic [ADDR_W-1:0] exp_err;
    } vec_t;
    vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;

    secded_scrubber #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe seen must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wr_data), 32'(e.data));
            end
        end
    end

    task automatic load_and_expect(input vec_t v, output int n_wr);
        n_wr = 0;
        for (int a = 0; a < DEPTH; a++) begin
            logic is_sp;
            is_sp  = (ADDR_W'(a) == v.sp_addr);
            mem[a] = is_sp ? v.sp_val : v.fill;
            if (WB && (is_sp ? v.sp_corr : v.fill_corr)) begin
                exp_q.push_back('{addr: ADDR_W'(a), data: (is_sp ? v.sp_fix : v.fill_fix)});
                n_wr++;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int exp_cycles, input int mid_start,
                             input int exp_corr, input int exp_uncorr, input logic [ADDR_W-1:0] exp_err);
        int done_cycle;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        done_cycle = -1;
        for (int c = 1; c <= 80; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == mid_start);
            if (done === 1'b1) begin
                done_cycle = c;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_cycle), 32'(exp_cycles));
        check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
        check({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
        check({tag, "_err_addr"}, 32'(err_addr), 32'(exp_err));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(mem_wr_data), 32'd0);
        check({tag, "_corr"}, 32'(corr_cnt), 32'd0);
        check({tag, "_uncorr"}, 32'(uncorr_cnt), 32'd0);
        check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    endtask

    initial begin
        int n_wr;
        bit hit;
        // 0x0A27 is data 0xA5 encoded; 0x0A67 flips index 6 (syndrome 7).
        vecs[0] = '{13'h0000, 1'b0, 13'h0000, 4'd0,  13'h0000, 1'b0, 13'h0000, 0, 0, 4'd0};
        vecs[1] = '{13'h0000, 1'b0, 13'h0000, 4'd3,  13'h0010, 1'b1, 13'h0000, 1, 0, 4'd0};
        vecs[2] = '{13'h0000, 1'b0, 13'h0000, 4'd5,  13'h1000, 1'b1, 13'h0000, 1, 0, 4'd0};
        vecs[3] = '{13'h0000, 1'b0, 13'h0000, 4'd7,  13'h0003, 1'b0, 13'h0000, 0, 1, 4'd7};
        vecs[4] = '{13'h0000, 1'b0, 13'h0000, 4'd15, 13'h0800, 1'b1, 13'h0000, 1, 0, 4'd7};
        vecs[5] = '{13'h0000, 1'b0, 13'h0000, 4'd15, 13'h0089, 1'b0, 13'h0000, 0, 1, 4'd15};
        vecs[6] = '{13'h0A27, 1'b0, 13'h0A27, 4'd0,  13'h0A67, 1'b1, 13'h0A27, 1, 0, 4'd15};
        vecs[7] = '{13'h0010, 1'b1, 13'h0000, 4'd0,  13'h0010, 1'b1, 13'h0000, 7, 0, 4'd15};
        vecs[8] = '{13'h0003, 1'b0, 13'h0003, 4'd0,  13'h0003, 1'b0, 13'h0003, 0, 7, 4'd15};
        vecs[9] = '{13'h0000, 1'b0, 13'h0000, 4'd12, 13'h1001, 1'b0, 13'h0000, 0, 1, 4'd12};

        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            load_and_expect(vecs[i], n_wr);
            run_sweep($sformatf("v%0d", i), 33 + (WB ? n_wr : 0), 0,
                      vecs[i].exp_corr, vecs[i].exp_uncorr, vecs[i].exp_err);
        end

        // Start pulsed mid-sweep must neither restart the sweep nor clear the counters.
        load_and_expect(vecs[1], n_wr);
        run_sweep("midstart", 33 + (WB ? n_wr : 0), 10, 1, 0, 4'd12);

        // Reset while the word at address 9 is being handled (in WRITE when writeback is built in).
        load_and_expect('{13'h0000, 1'b0, 13'h0000, 4'd9, 13'h0010, 1'b1, 13'h0000, 0, 0, 4'd0}, n_wr);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == 5);
            if (mem_addr == 4'd9 && (WB ? (mem_wr_en === 1'b1) : (busy === 1'b1))) begin
                hit = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("rstwr_reached", 32'(hit), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("rstwr");
        @(posedge clk);
        @(negedge clk);
        check("rstwr_mem9_untouched", 32'(mem[9]), 32'h0010);
        check("rstwr_writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b0;

        load_and_expect(vecs[0], n_wr);
        run_sweep("post_rst", 33, 0, 0, 0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
